// File: rtl/shifter_pkg.sv
// shifter_pkg: op codes, per-op funnel decode and bit-reverse helper for funnel_shift_pipe.
package shifter_pkg;
    localparam int MAXW = 64;

    typedef enum logic [3:0] {
        OP_SRL = 4'd0,
        OP_SRA = 4'd1,
        OP_SLL = 4'd2,
        OP_SRO = 4'd3,
        OP_SLO = 4'd4,
        OP_ROR = 4'd5,
        OP_ROL = 4'd6,
        OP_FSR = 4'd7,
        OP_FSL = 4'd8
    } op_e;

    typedef enum logic [2:0] {H_ZERO, H_SIGN, H_ONES, H_A, H_B} h_sel_e;
    typedef enum logic {L_A, L_ZERO} l_sel_e;

    typedef struct packed {
        h_sel_e h;
        l_sel_e l;
        logic   rev;
        logic   ill;
    } dec_t;

    // Left ops reuse the right funnel on bit-reversed operands; illegal ops funnel zeros.
    function automatic dec_t decode(input logic [3:0] op);
        dec_t d;
        d = '{h: H_ZERO, l: L_A, rev: 1'b0, ill: 1'b0};
        case (op)
            OP_SRL: d.h = H_ZERO;
            OP_SRA: d.h = H_SIGN;
            OP_SLL: d.rev = 1'b1;
            OP_SRO: d.h = H_ONES;
            OP_SLO: begin d.h = H_ONES; d.rev = 1'b1; end
            OP_ROR: d.h = H_A;
            OP_ROL: begin d.h = H_A; d.rev = 1'b1; end
            OP_FSR: d.h = H_B;
            OP_FSL: begin d.h = H_B; d.rev = 1'b1; end
            default: begin d.l = L_ZERO; d.ill = 1'b1; end
        endcase
        return d;
    endfunction

    function automatic logic [MAXW-1:0] bitrev(input logic [MAXW-1:0] x, input int w);
        logic [MAXW-1:0] r;
        r = '0;
        for (int i = 0; i < MAXW; i++)
            if (i < w) r[i] = x[w-1-i];
        return r;
    endfunction
endpackage

// File: rtl/funnel_level.sv
// funnel_level: one mux level of the right funnel, shifting {h,l} right by W when sel_i is set.
module funnel_level #(
    parameter int XLEN = 32,
    parameter int W    = 1
) (
    input  logic            sel_i,
    input  logic [XLEN-1:0] h_i,
    input  logic [XLEN-1:0] l_i,
    output logic [XLEN-1:0] h_o,
    output logic [XLEN-1:0] l_o
);
    assign l_o = sel_i ? {h_i[W-1:0], l_i[XLEN-1:W]} : l_i;
    assign h_o = sel_i ? h_i >> W : h_i;
endmodule

// File: rtl/funnel_shift_pipe.sv
// funnel_shift_pipe: pipelined shift/rotate/funnel unit built on a single right funnel {H,L}>>s
// with per-stage valid bits and collapsing bubbles.
module funnel_shift_pipe
    import shifter_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAGW   = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_op,
    input  logic [XLEN-1:0]         in_a,
    input  logic [XLEN-1:0]         in_b,
    input  logic [$clog2(XLEN)-1:0] in_shamt,
    input  logic [TAGW-1:0]         in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_y,
    output logic                    out_err,
    output logic [TAGW-1:0]         out_tag
);
    localparam int LW   = $clog2(XLEN);
    localparam int LAST = STAGES - 1;

    function automatic logic [XLEN-1:0] rev(input logic [XLEN-1:0] x);
        return XLEN'(bitrev(MAXW'(x), XLEN));
    endfunction

    logic [STAGES-1:0] vld_q, vld_in, adv, err_q, err_in;
    logic              rev_q  [STAGES];
    logic              rev_in [STAGES];
    logic [XLEN-1:0]   h_q    [STAGES];
    logic [XLEN-1:0]   l_q    [STAGES];
    logic [XLEN-1:0]   h_in   [STAGES];
    logic [XLEN-1:0]   l_in   [STAGES];
    logic [XLEN-1:0]   h_d    [STAGES];
    logic [XLEN-1:0]   l_mid  [STAGES];
    logic [XLEN-1:0]   l_d    [STAGES];
    logic [LW-1:0]     sh_q   [STAGES];
    logic [LW-1:0]     sh_in  [STAGES];
    logic [TAGW-1:0]   tag_q  [STAGES];
    logic [TAGW-1:0]   tag_in [STAGES];
    logic [XLEN-1:0]   lh     [LW];
    logic [XLEN-1:0]   ll     [LW];

    dec_t            dec;
    logic [XLEN-1:0] h0, l0;
    logic            full;

    always_comb begin
        dec = decode(in_op);
        h0  = dec.h == H_SIGN ? {XLEN{in_a[XLEN-1]}} :
              dec.h == H_ONES ? {XLEN{1'b1}} :
              dec.h == H_A    ? in_a :
              dec.h == H_B    ? in_b : '0;
        l0  = dec.l == L_A ? in_a : '0;
    end

    // A stage may move when any stage from it to the output is empty, or the output is taken.
    always_comb begin
        full = 1'b1;
        adv  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            full   = full & vld_q[k];
            adv[k] = out_ready || !full;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        if (k == 0) begin : g_first
            assign vld_in[k] = in_valid;
            assign h_in[k]   = dec.rev ? rev(h0) : h0;
            assign l_in[k]   = dec.rev ? rev(l0) : l0;
            assign sh_in[k]  = in_shamt;
            assign rev_in[k] = dec.rev;
            assign err_in[k] = dec.ill;
            assign tag_in[k] = in_tag;
        end else begin : g_next
            assign vld_in[k] = vld_q[k-1];
            assign h_in[k]   = h_q[k-1];
            assign l_in[k]   = l_q[k-1];
            assign sh_in[k]  = sh_q[k-1];
            assign rev_in[k] = rev_q[k-1];
            assign err_in[k] = err_q[k-1];
            assign tag_in[k] = tag_q[k-1];
        end
        if (k == LAST) begin : g_out
            assign l_d[k] = rev_in[k] ? rev(l_mid[k]) : l_mid[k];
        end else begin : g_mid
            assign l_d[k] = l_mid[k];
        end
    end

    // Levels go from the largest weight down; level i lives in stage (i*STAGES)/LW.
    for (genvar i = 0; i < LW; i++) begin : g_lvl
        localparam int K = (i * STAGES) / LW;
        logic [XLEN-1:0] hi, li;
        if (i == 0 || ((i - 1) * STAGES) / LW != K) begin : g_head
            assign hi = h_in[K];
            assign li = l_in[K];
        end else begin : g_chain
            assign hi = lh[i-1];
            assign li = ll[i-1];
        end
        funnel_level #(.XLEN(XLEN), .W(1 << (LW - 1 - i))) u_lvl (
            .sel_i (sh_in[K][LW-1-i]),
            .h_i   (hi),
            .l_i   (li),
            .h_o   (lh[i]),
            .l_o   (ll[i])
        );
        if (i == LW - 1 || ((i + 1) * STAGES) / LW != K) begin : g_tail
            assign h_d[K]   = lh[i];
            assign l_mid[K] = ll[i];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_q <= '0;
            err_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                h_q[k]   <= '0;
                l_q[k]   <= '0;
                sh_q[k]  <= '0;
                rev_q[k] <= 1'b0;
                tag_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    vld_q[k] <= vld_in[k];
                    if (vld_in[k]) begin
                        h_q[k]   <= h_d[k];
                        l_q[k]   <= l_d[k];
                        sh_q[k]  <= sh_in[k];
                        rev_q[k] <= rev_in[k];
                        err_q[k] <= err_in[k];
                        tag_q[k] <= tag_in[k];
                    end
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_q[LAST];
    assign out_y     = l_q[LAST];
    assign out_err   = err_q[LAST];
    assign out_tag   = tag_q[LAST];
endmodule

// File: tb/tb_funnel_shift_pipe.sv
// tb_funnel_shift_pipe: directed and randomised checks of funnel_shift_pipe against an arithmetic model.
module tb_funnel_shift_pipe;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_y(input int w, input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input int s);
        logic [63:0]  m, am, bm, r;
        logic [127:0] t;
        m  = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
        am = a & m;
        bm = b & m;
        case (op)
            4'd0: r = am >> s;
            4'd1: r = (am >> s) | (am[w-1] ? (m & ~(m >> s)) : 64'd0);
            4'd2: r = am << s;
            4'd3: r = ~((~am & m) >> s);
            4'd4: r = ~((~am & m) << s);
            4'd5: begin t = (128'(am) << w) | 128'(am); r = 64'(t >> s); end
            4'd6: begin t = (128'(am) << w) | 128'(am); t = t << s; r = 64'(t >> w); end
            4'd7: begin t = (128'(bm) << w) | 128'(am); r = 64'(t >> s); end
            4'd8: begin t = (128'(am) << w) | 128'(bm); t = t << s; r = 64'(t >> w); end
            default: r = 64'd0;
        endcase
        return r & m;
    endfunction

    logic        d_valid = 1'b0, d_ordy = 1'b1, d_rdy, d_ov, d_err;
    logic [3:0]  d_op = '0, d_tag = '0, d_otag;
    logic [31:0] d_a = '0, d_b = '0, d_y;
    logic [4:0]  d_s = '0;

    funnel_shift_pipe #(.XLEN(32), .STAGES(2), .TAGW(4)) u_dut (
        .clk(clk), .resetn(resetn), .in_valid(d_valid), .in_ready(d_rdy), .in_op(d_op),
        .in_a(d_a), .in_b(d_b), .in_shamt(d_s), .in_tag(d_tag), .out_valid(d_ov),
        .out_ready(d_ordy), .out_y(d_y), .out_err(d_err), .out_tag(d_otag)
    );

    logic        r_valid = 1'b0, r_ordy = 1'b1, drain_chk = 1'b0;
    logic [3:0]  r_op = '0, r_tag = '0;
    logic [63:0] r_a = '0, r_b = '0;
    logic [5:0]  r_s = '0;

    function automatic int cfg_x(input int c);
        return c == 3 ? 8 : c == 4 ? 64 : 32;
    endfunction

    function automatic int cfg_s(input int c);
        return c == 0 ? 2 : c == 1 ? 1 : c == 4 ? 5 : 3;
    endfunction

    for (genvar c = 0; c < 5; c++) begin : g_cfg
        localparam int XL = cfg_x(c);
        localparam int ST = cfg_s(c);
        localparam int LX = $clog2(XL);
        logic          rdy, ov, oe;
        logic [XL-1:0] oy;
        logic [3:0]    otag;
        logic [63:0]   q_y[$];
        logic          q_e[$];
        logic [3:0]    q_t[$];
        logic          drained = 1'b0;

        funnel_shift_pipe #(.XLEN(XL), .STAGES(ST), .TAGW(4)) u_dut (
            .clk(clk), .resetn(resetn), .in_valid(r_valid), .in_ready(rdy), .in_op(r_op),
            .in_a(r_a[XL-1:0]), .in_b(r_b[XL-1:0]), .in_shamt(r_s[LX-1:0]), .in_tag(r_tag),
            .out_valid(ov), .out_ready(r_ordy), .out_y(oy), .out_err(oe), .out_tag(otag)
        );

        always @(negedge clk) begin
            if (ov && r_ordy) begin
                if (q_y.size() == 0) begin
                    check($sformatf("cfg%0d_spurious", c), 64'(ov), 64'd0);
                end else begin
                    check($sformatf("cfg%0d_y", c), 64'(oy), q_y.pop_front());
                    check($sformatf("cfg%0d_err", c), 64'(oe), 64'(q_e.pop_front()));
                    check($sformatf("cfg%0d_tag", c), 64'(otag), 64'(q_t.pop_front()));
                end
            end
            if (r_valid && rdy) begin
                q_y.push_back(ref_y(XL, r_op, r_a, r_b, int'(r_s[LX-1:0])));
                q_e.push_back(r_op > 4'd8);
                q_t.push_back(r_tag);
            end
            if (drain_chk && !drained) begin
                check($sformatf("cfg%0d_drain", c), 64'(q_y.size()), 64'd0);
                drained = 1'b1;
            end
        end
    end

    task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] s, input logic [3:0] tg, input logic [31:0] ey, input logic ee);
        int k;
        @(posedge clk); #1;
        d_valid = 1'b1; d_op = op; d_a = a; d_b = b; d_s = s; d_tag = tg; d_ordy = 1'b1;
        k = 0;
        while (!d_rdy && k < 20) begin @(posedge clk); #1; k++; end
        @(posedge clk); #1;
        d_valid = 1'b0;
        k = 1;
        while (!d_ov && k < 20) begin @(posedge clk); #1; k++; end
        check({nm, "_lat"}, 64'(k), 64'd2);
        check({nm, "_y"}, 64'(d_y), 64'(ey));
        check({nm, "_err"}, 64'(d_err), 64'(ee));
        check({nm, "_tag"}, 64'(d_otag), 64'(tg));
    endtask

    logic [3:0]  sop [8];
    logic [31:0] sa [8], sb [8], sy [8];
    logic [4:0]  ss [8];

    initial begin
        int sent, got, cnt;
        logic stalled;
        logic [31:0] hy;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(d_ov), 64'd0);
        check("rst_y", 64'(d_y), 64'd0);
        check("rst_err", 64'(d_err), 64'd0);
        check("rst_tag", 64'(d_otag), 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("rel_ready", 64'(d_rdy), 64'd1);

        run_op("sra", 4'd1, 32'h80000000, 32'h0, 5'd4, 4'd1, 32'hF8000000, 1'b0);
        run_op("fsl", 4'd8, 32'h12345678, 32'h9ABCDEF0, 5'd8, 4'd2, 32'h3456789A, 1'b0);
        run_op("fsr", 4'd7, 32'h12345678, 32'h9ABCDEF0, 5'd8, 4'd3, 32'hF0123456, 1'b0);
        run_op("rol", 4'd6, 32'h80000001, 32'h0, 5'd1, 4'd4, 32'h00000003, 1'b0);
        run_op("slo", 4'd4, 32'h0, 32'h0, 5'd4, 4'd5, 32'h0000000F, 1'b0);
        run_op("sro", 4'd3, 32'h0, 32'h0, 5'd4, 4'd6, 32'hF0000000, 1'b0);
        for (int o = 0; o < 9; o++)
            run_op($sformatf("s0_op%0d", o), 4'(o), 32'hDEADBEEF, 32'h0F1E2D3C, 5'd0, 4'(o), 32'hDEADBEEF, 1'b0);
        run_op("ill", 4'hF, 32'h12345678, 32'hFFFFFFFF, 5'd5, 4'd3, 32'h0, 1'b1);
        run_op("post_ill", 4'd0, 32'h00000100, 32'h0, 5'd4, 4'd7, 32'h00000010, 1'b0);

        for (int j = 0; j < 8; j++) begin
            sop[j] = 4'($urandom_range(0, 8));
            sa[j]  = $urandom;
            sb[j]  = $urandom;
            ss[j]  = 5'($urandom);
            sy[j]  = 32'(ref_y(32, sop[j], 64'(sa[j]), 64'(sb[j]), int'(ss[j])));
        end
        sent = 0; got = 0; stalled = 1'b0; hy = '0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(posedge clk); #1;
            d_valid = sent < 8;
            if (sent < 8) begin
                d_op = sop[sent]; d_a = sa[sent]; d_b = sb[sent]; d_s = ss[sent]; d_tag = 4'(sent);
            end
            d_ordy = !(cyc >= 3 && cyc < 8);
            @(negedge clk);
            if (cyc == 5) begin
                check("stall_ready", 64'(d_rdy), 64'd0);
                check("stall_inflight", 64'(sent - got), 64'd2);
            end
            if (d_ov && !d_ordy) begin
                if (!stalled) begin hy = d_y; stalled = 1'b1; end
                else check("stall_y", 64'(d_y), 64'(hy));
            end
            if (d_ov && d_ordy) begin
                check("strm_tag", 64'(d_otag), 64'(got));
                check("strm_y", 64'(d_y), 64'(sy[got]));
                got++;
            end
            if (d_valid && d_rdy) sent++;
        end
        @(posedge clk); #1;
        d_valid = 1'b0;
        check("strm_count", 64'(got), 64'd8);
        repeat (3) begin
            @(negedge clk);
            check("strm_extra", 64'(d_ov), 64'd0);
        end

        @(posedge clk); #1;
        d_ordy = 1'b0; d_valid = 1'b1; d_op = 4'd0; d_a = 32'h1; d_s = 5'd0; d_tag = 4'd9;
        @(posedge clk); #1;
        d_tag = 4'd10;
        @(posedge clk); #1;
        d_valid = 1'b0;
        check("fly_valid", 64'(d_ov), 64'd1);
        check("fly_tag", 64'(d_otag), 64'd9);
        #2 resetn = 1'b0;
        #1;
        check("arst_valid", 64'(d_ov), 64'd0);
        check("arst_y", 64'(d_y), 64'd0);
        check("arst_tag", 64'(d_otag), 64'd0);
        @(posedge clk);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        check("arst_ready", 64'(d_rdy), 64'd1);
        d_ordy = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (d_ov) cnt++;
        end
        check("arst_discard", 64'(cnt), 64'd0);

        for (int n = 0; n < 800; n++) begin
            @(posedge clk); #1;
            r_valid = ($urandom % 4) != 0;
            r_op    = 4'($urandom_range(0, 9));
            r_a     = {$urandom, $urandom};
            r_b     = {$urandom, $urandom};
            r_s     = ($urandom % 8 == 0) ? 6'd0 : 6'($urandom);
            r_tag   = 4'($urandom);
            r_ordy  = ($urandom % 4) != 0;
        end
        @(posedge clk); #1;
        r_valid = 1'b0;
        r_ordy  = 1'b1;
        repeat (20) @(posedge clk);
        #1 drain_chk = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
